// File: rtl/lbist_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module : lbist_pattern_engine
// Brief  : LFSR pattern source and MISR response compactor with a pass/fail
//          verdict for a 14-in / 8-out combinational core under self-test.
// Rev    : 1.0
// ============================================================================
module lbist_pattern_engine #(
  parameter int PAT_W    = 14,
  parameter int RESP_W   = 8,
  parameter int CNT_W    = 16,
  parameter int RESP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [PAT_W-1:0]  seed_i,
  input  logic [CNT_W-1:0]  num_pat_i,
  input  logic [RESP_W-1:0] expected_sig_i,
  input  logic [RESP_W-1:0] resp_i,
  output logic [PAT_W-1:0]  pat_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [RESP_W-1:0] signature_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Bit 0 of the valid pipe is high while pat_o shows a freshly issued
  // pattern; bit RESP_LAT marks the cycle its response is on resp_i.
  localparam int c_vpipe_w = RESP_LAT + 1;
  localparam logic [c_vpipe_w-1:0] c_drain_mask = {c_vpipe_w{1'b1}} >> 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PAT_W-1:0]    r_seed;
  logic [PAT_W-1:0]    r_pat;
  logic [CNT_W-1:0]    r_num_pat;
  logic [CNT_W-1:0]    r_issued;
  logic [RESP_W-1:0]   r_expected;
  logic [RESP_W-1:0]   r_misr;
  logic [c_vpipe_w-1:0] r_vpipe;
  logic                r_done;
  logic                r_pass;

  logic                w_accept;
  logic                w_issue;
  logic                w_drain_exit;
  logic                w_absorb;
  logic [RESP_W-1:0]   w_misr_fin;
  logic [PAT_W-1:0]    w_seed_eff;
  logic [CNT_W-1:0]    w_num_eff;

  function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] s);
    return {s[PAT_W-2:0], s[PAT_W-1] ^ s[4] ^ s[2] ^ s[0]};
  endfunction

  function automatic logic [RESP_W-1:0] misr_next(input logic [RESP_W-1:0] m,
                                                  input logic [RESP_W-1:0] r);
    return {m[RESP_W-2:0], m[RESP_W-1] ^ m[5] ^ m[4] ^ m[3]} ^ r;
  endfunction

  // An all-zero seed would lock the LFSR, and a zero count still runs once.
  assign w_seed_eff = (seed_i == '0) ? PAT_W'(1) : seed_i;
  assign w_num_eff  = (num_pat_i == '0) ? CNT_W'(1) : num_pat_i;

  assign w_absorb   = r_vpipe[RESP_LAT] & ~abort_i;
  assign w_misr_fin = w_absorb ? misr_next(r_misr, resp_i) : r_misr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_drain_exit = 1'b0;
    if (abort_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            w_state_nxt = S_SEED;
            w_accept    = 1'b1;
          end
        end
        S_SEED: begin
          w_state_nxt = S_RUN;
          w_issue     = 1'b1;
        end
        S_RUN: begin
          if (r_issued < r_num_pat) begin
            w_issue = 1'b1;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Leave once only the final response (if any) remains in the pipe.
          if ((r_vpipe & c_drain_mask) == '0) begin
            w_state_nxt  = S_DONE;
            w_drain_exit = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed     <= '0;
      r_pat      <= '0;
      r_num_pat  <= '0;
      r_issued   <= '0;
      r_expected <= '0;
      r_misr     <= '0;
      r_vpipe    <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort_i) begin
        r_vpipe <= '0;
        r_pass  <= 1'b0;
      end else begin
        r_vpipe <= (r_vpipe << 1) | c_vpipe_w'(w_issue);
        if (w_accept) begin
          r_seed     <= w_seed_eff;
          r_num_pat  <= w_num_eff;
          r_expected <= expected_sig_i;
          r_issued   <= '0;
          r_misr     <= '0;
          r_pass     <= 1'b0;
        end
        if (w_issue) begin
          if (r_state == S_SEED) begin
            r_pat    <= r_seed;
            r_issued <= CNT_W'(1);
          end else begin
            r_pat    <= lfsr_next(r_pat);
            r_issued <= r_issued + CNT_W'(1);
          end
        end
        if (w_absorb) begin
          r_misr <= w_misr_fin;
        end
        if (w_drain_exit) begin
          r_done <= 1'b1;
          r_pass <= (w_misr_fin == r_expected);
        end
      end
    end
  end

  assign pat_o       = r_pat;
  assign busy_o      = (r_state == S_SEED) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign signature_o = r_misr;

endmodule
`default_nettype wire

// File: tb/tb_lbist_pattern_engine.sv
`default_nettype none
// Bench for lbist_pattern_engine: three instances (RESP_LAT 1, 0, 3) share
// start/seed/count and are checked against a pattern-by-pattern reference.
module tb_lbist_pattern_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [13:0] seed_i = '0;
  logic [15:0] num_pat_i = '0;
  logic [7:0]  expected_sig_i = '0;

  logic [7:0]  resp_const = '0;
  bit          use_core = 1'b0;
  bit          fault_en = 1'b0;
  logic [13:0] fault_pat = '0;

  logic [2:0][13:0] pat;
  logic [2:0][7:0]  sig;
  logic [2:0][7:0]  resp;
  logic [2:0]       busy, done, pass;
  logic [13:0]      d0_1, d2_1, d2_2, d2_3;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0]  r_sig [3];
  logic        r_pass [3];
  int          r_done_cnt [3];
  int          r_busy;
  bit          r_timeout;
  logic        r_pass_at_seed;
  logic [13:0] pats [$];

  always #5 clk = ~clk;

  lbist_pattern_engine #(.RESP_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .seed_i(seed_i),
    .num_pat_i(num_pat_i), .expected_sig_i(expected_sig_i), .resp_i(resp[0]),
    .pat_o(pat[0]), .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .signature_o(sig[0]));

  lbist_pattern_engine #(.RESP_LAT(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .seed_i(seed_i),
    .num_pat_i(num_pat_i), .expected_sig_i(expected_sig_i), .resp_i(resp[1]),
    .pat_o(pat[1]), .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .signature_o(sig[1]));

  lbist_pattern_engine #(.RESP_LAT(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .seed_i(seed_i),
    .num_pat_i(num_pat_i), .expected_sig_i(expected_sig_i), .resp_i(resp[2]),
    .pat_o(pat[2]), .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]), .signature_o(sig[2]));

  // Arbitrary nonlinear stand-in for the mapped benchmark core.
  function automatic logic [7:0] core_fn(input logic [13:0] p);
    logic [7:0] a, b;
    a = p[7:0];
    b = {p[13:8], p[13:12]};
    return ((a ^ b) + (a & {b[3:0], b[7:4]})) ^ {p[0], p[13:7]};
  endfunction

  function automatic logic [7:0] resp_of(input logic [13:0] p, input bit uc, input bit fe,
                                         input logic [13:0] fp, input logic [7:0] rc);
    logic [7:0] r;
    r = uc ? core_fn(p) : rc;
    if (uc && fe && p == fp) r = r ^ 8'h04;
    return r;
  endfunction

  // Core output latency: combinational, one register, three registers.
  always @(posedge clk) begin
    d0_1 <= pat[0];
    d2_1 <= pat[2];
    d2_2 <= d2_1;
    d2_3 <= d2_2;
  end
  assign resp[0] = resp_of(d0_1,   use_core, fault_en, fault_pat, resp_const);
  assign resp[1] = resp_of(pat[1], use_core, fault_en, fault_pat, resp_const);
  assign resp[2] = resp_of(d2_3,   use_core, fault_en, fault_pat, resp_const);

  function automatic logic [13:0] lfsr_step(input logic [13:0] s);
    return {s[12:0], s[13] ^ s[4] ^ s[2] ^ s[0]};
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [7:0] r);
    return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ r;
  endfunction

  function automatic logic [13:0] model_pat(input logic [13:0] seed, input int k);
    logic [13:0] s;
    s = (seed == 14'h0) ? 14'h0001 : seed;
    for (int i = 0; i < k; i++) s = lfsr_step(s);
    return s;
  endfunction

  // Signature of n patterns; fidx >= 0 flips response bit 2 of that pattern.
  function automatic logic [7:0] model_sig(input logic [13:0] seed, input int num, input bit uc,
                                           input logic [7:0] rc, input int fidx);
    logic [13:0] s;
    logic [7:0]  m, r;
    int          n;
    s = (seed == 14'h0) ? 14'h0001 : seed;
    n = (num == 0) ? 1 : num;
    m = 8'h00;
    for (int k = 0; k < n; k++) begin
      r = uc ? core_fn(s) : rc;
      if (k == fidx) r = r ^ 8'h04;
      m = misr_step(m, r);
      s = lfsr_step(s);
    end
    return m;
  endfunction

  task automatic run(input logic [13:0] seed, input logic [15:0] num, input logic [7:0] exp_sig,
                     input int limit, input int poke);
    bit [2:0] seen;
    int cyc;
    pats.delete();
    r_busy = 0;
    r_timeout = 1'b0;
    seen = '0;
    for (int i = 0; i < 3; i++) begin
      r_done_cnt[i] = 0;
      r_sig[i] = 8'hxx;
      r_pass[i] = 1'bx;
    end
    @(negedge clk);
    seed_i = seed; num_pat_i = num; expected_sig_i = exp_sig; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    seed_i = 14'($urandom); num_pat_i = 16'($urandom); expected_sig_i = 8'($urandom);
    r_pass_at_seed = pass[0];
    cyc = 0;
    while (seen != 3'b111 && cyc < limit) begin
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          r_done_cnt[i]++;
          seen[i] = 1'b1;
          r_sig[i] = sig[i];
          r_pass[i] = pass[i];
        end
      end
      if (busy[0]) begin
        r_busy++;
        if (r_busy > 1 && (pats.size() == 0 || pats[$] != pat[0])) pats.push_back(pat[0]);
      end
      start_i = (cyc == poke);
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    r_timeout = (seen != 3'b111);
    repeat (6) begin
      for (int i = 0; i < 3; i++) if (done[i]) r_done_cnt[i]++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (pat !== '0)  $display("FAIL reset_pat: got %h want 0", pat);   else n_pass++;
    n_checks++; if (sig !== '0)  $display("FAIL reset_sig: got %h want 0", sig);   else n_pass++;
    n_checks++; if (busy !== '0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== '0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (pass !== '0) $display("FAIL reset_pass: got %b want 0", pass); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_sequence();
    logic [13:0] exp_p [3];
    logic [7:0]  m;
    exp_p[0] = 14'h0001; exp_p[1] = 14'h0003; exp_p[2] = 14'h0007;
    use_core = 1'b0; resp_const = 8'h5A;
    m = model_sig(14'h0001, 3, 1'b0, 8'h5A, -1);
    run(14'h0001, 16'd3, m, 60, -1);
    n_checks++; if (r_timeout !== 1'b0) $display("FAIL basic_timeout: done never seen"); else n_pass++;
    n_checks++; if (pats.size() !== 3) $display("FAIL basic_npat: got %0d want 3", pats.size()); else n_pass++;
    for (int k = 0; k < 3 && k < pats.size(); k++) begin
      n_checks++;
      if (pats[k] !== exp_p[k]) $display("FAIL basic_pat%0d: got %h want %h", k, pats[k], exp_p[k]);
      else n_pass++;
    end
    n_checks++; if (r_busy !== 5) $display("FAIL basic_busy: got %0d want 5", r_busy); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r_done_cnt[i] !== 1) $display("FAIL basic_done%0d: got %0d want 1", i, r_done_cnt[i]); else n_pass++;
      n_checks++;
      if (r_sig[i] !== m || r_pass[i] !== 1'b1)
        $display("FAIL basic_sig%0d: got %h/%b want %h/1", i, r_sig[i], r_pass[i], m);
      else n_pass++;
    end
  endtask

  task automatic test_zero_resp();
    use_core = 1'b0; resp_const = 8'h00;
    run(14'h0ABC, 16'd5, 8'h00, 60, -1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r_sig[i] !== 8'h00 || r_pass[i] !== 1'b1)
        $display("FAIL zero_match%0d: got %h/%b want 00/1", i, r_sig[i], r_pass[i]);
      else n_pass++;
    end
    run(14'h0ABC, 16'd5, 8'h01, 60, -1);
    n_checks++; if (r_pass_at_seed !== 1'b0) $display("FAIL zero_pass_clear: got %b want 0", r_pass_at_seed); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r_sig[i] !== 8'h00 || r_pass[i] !== 1'b0)
        $display("FAIL zero_mismatch%0d: got %h/%b want 00/0", i, r_sig[i], r_pass[i]);
      else n_pass++;
    end
    n_checks++; if (pass !== 3'b000) $display("FAIL zero_hold: got %b want 000", pass); else n_pass++;
  endtask

  task automatic test_single_and_zero_count();
    use_core = 1'b0; resp_const = 8'hFF;
    for (int pass_no = 0; pass_no < 2; pass_no++) begin
      run(14'h0155, (pass_no == 0) ? 16'd1 : 16'd0, 8'hFF, 40, -1);
      n_checks++; if (r_busy !== 3) $display("FAIL single_busy%0d: got %0d want 3", pass_no, r_busy); else n_pass++;
      n_checks++;
      if (pats.size() !== 1 || pats[0] !== 14'h0155)
        $display("FAIL single_pat%0d: got n=%0d want 1 x 0155", pass_no, pats.size());
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (r_sig[i] !== 8'hFF || r_pass[i] !== 1'b1 || r_done_cnt[i] !== 1)
          $display("FAIL single%0d_%0d: got %h/%b/%0d want FF/1/1", pass_no, i, r_sig[i], r_pass[i], r_done_cnt[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_seed_and_wrap();
    logic [7:0] m;
    use_core = 1'b0; resp_const = 8'h3C;
    run(14'h0000, 16'd4, 8'h00, 40, -1);
    n_checks++; if (pats.size() < 1 || pats[0] !== 14'h0001) $display("FAIL seed0_first: want 0001"); else n_pass++;
    use_core = 1'b1;
    m = model_sig(14'h0001, 16384, 1'b1, 8'h00, -1);
    run(14'h0001, 16'd16384, m, 16420, -1);
    n_checks++; if (r_timeout !== 1'b0) $display("FAIL wrap_timeout: done never seen"); else n_pass++;
    n_checks++; if (pats.size() !== 16384) $display("FAIL wrap_npat: got %0d want 16384", pats.size()); else n_pass++;
    n_checks++; if (pat[0] !== 14'h0001) $display("FAIL wrap_last: got %h want 0001", pat[0]); else n_pass++;
    n_checks++; if (pats.size() > 1 && pats[1] !== model_pat(14'h0001, 1)) $display("FAIL wrap_second: got %h", pats[1]); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r_sig[i] !== m || r_pass[i] !== 1'b1)
        $display("FAIL wrap_sig%0d: got %h/%b want %h/1", i, r_sig[i], r_pass[i], m);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int dcount;
    logic [13:0] s;
    logic [7:0] m;
    use_core = 1'b1; fault_en = 1'b0;
    @(negedge clk);
    seed_i = 14'h02A5; num_pat_i = 16'd10; expected_sig_i = 8'h00; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    n_checks++; if (busy !== 3'b000) $display("FAIL abort_busy: got %b want 000", busy); else n_pass++;
    n_checks++; if (pass !== 3'b000) $display("FAIL abort_pass: got %b want 000", pass); else n_pass++;
    dcount = 0;
    repeat (12) begin
      if (done !== 3'b000) dcount++;
      @(negedge clk);
    end
    n_checks++; if (dcount !== 0) $display("FAIL abort_done: got %0d pulses want 0", dcount); else n_pass++;
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    n_checks++; if (busy !== 3'b000) $display("FAIL abort_wins: got busy %b want 000", busy); else n_pass++;
    s = 14'($urandom);
    m = model_sig(s, 30, 1'b1, 8'h00, -1);
    run(s, 16'd30, m, 80, -1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r_sig[i] !== m || r_pass[i] !== 1'b1)
        $display("FAIL abort_rerun%0d: got %h/%b want %h/1", i, r_sig[i], r_pass[i], m);
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] m;
    use_core = 1'b1;
    m = model_sig(14'h1357, 20, 1'b1, 8'h00, -1);
    run(14'h1357, 16'd20, m, 80, 6);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r_sig[i] !== m || r_done_cnt[i] !== 1)
        $display("FAIL start_ignored%0d: got %h/%0d want %h/1", i, r_sig[i], r_done_cnt[i], m);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    int dcount;
    use_core = 1'b1;
    @(negedge clk);
    seed_i = 14'h0777; num_pat_i = 16'd40; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pat !== '0 || sig !== '0 || busy !== '0 || pass !== '0)
      $display("FAIL midrun_reset: got pat %h sig %h busy %b pass %b want all 0", pat, sig, busy, pass);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (50) begin
      if (done !== 3'b000 || busy !== 3'b000) dcount++;
      @(negedge clk);
    end
    n_checks++; if (dcount !== 0) $display("FAIL midrun_quiet: got %0d active cycles want 0", dcount); else n_pass++;
  endtask

  task automatic test_core_model();
    logic [13:0] s;
    logic [7:0]  m, mf;
    use_core = 1'b1; fault_en = 1'b0;
    s = 14'($urandom);
    m = model_sig(s, 1000, 1'b1, 8'h00, -1);
    run(s, 16'd1000, m, 1040, -1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r_sig[i] !== m || r_pass[i] !== 1'b1)
        $display("FAIL core_clean%0d: got %h/%b want %h/1", i, r_sig[i], r_pass[i], m);
      else n_pass++;
    end
    fault_pat = model_pat(s, 499);
    fault_en = 1'b1;
    mf = model_sig(s, 1000, 1'b1, 8'h00, 499);
    run(s, 16'd1000, m, 1040, -1);
    fault_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r_sig[i] !== mf || r_pass[i] !== 1'b0)
        $display("FAIL core_fault%0d: got %h/%b want %h/0", i, r_sig[i], r_pass[i], mf);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [13:0] s;
    logic [7:0]  m, e;
    int          n;
    bit          coin;
    use_core = 1'b1;
    for (int it = 0; it < 4; it++) begin
      s = 14'($urandom);
      n = $urandom_range(1, 300);
      coin = 1'($urandom);
      m = model_sig(s, n, 1'b1, 8'h00, -1);
      e = coin ? m : (m ^ (8'h01 << $urandom_range(0, 7)));
      run(s, 16'(n), e, n + 40, -1);
      n_checks++; if (r_busy !== n + 2) $display("FAIL rand%0d_busy: got %0d want %0d", it, r_busy, n + 2); else n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (r_sig[i] !== m || r_pass[i] !== coin || r_done_cnt[i] !== 1)
          $display("FAIL rand%0d_%0d: got %h/%b/%0d want %h/%b/1", it, i, r_sig[i], r_pass[i], r_done_cnt[i], m, coin);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sequence();
    test_zero_resp();
    test_single_and_zero_count();
    test_seed_and_wrap();
    test_abort();
    test_start_ignored();
    test_reset_midrun();
    test_core_model();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
